// File: rtl/mips_multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control unit: states, opcodes,
// datapath mux selects, ALU commands and the control output bundle.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXEC    = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_JUMP    = 4'd9,
        S_ADDI_EX = 4'd10,
        S_ADDI_WB = 4'd11
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_ADDI  = 6'h08;

    localparam logic [1:0] SRCB_REGB    = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [5:0] ALU_ADD_OP   = 6'h23;
    localparam logic [5:0] ALU_SUB_OP   = 6'h04;
    localparam logic [5:0] ALU_RTYPE_OP = 6'h00;

    typedef struct packed {
        logic       mem_read;
        logic       mem_write;
        logic       iord;
        logic       ir_write;
        logic       pc_en;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_source;
        logic [5:0] alu_opcode;
        logic [5:0] alu_func;
        logic       retire;
    } ctrl_t;

    // Idle bundle: every strobe low, every select zero, ALU commanded to add.
    function automatic ctrl_t ctrl_default();
        ctrl_t c;
        c            = '0;
        c.alu_opcode = ALU_ADD_OP;
        return c;
    endfunction

endpackage

// File: rtl/mips_multicycle_ctrl_outdec.sv
// Combinational decode of the registered state (plus mem_ready, alu_zero,
// instr_func) into every datapath control output of the multicycle MIPS.
// Ports: state in, mem_ready/alu_zero in, instr_func[5:0] in, ctrl bundle out.
module mips_ctrl_outdec
    import mips_ctrl_pkg::*;
(
    input  state_e     state,
    input  logic       mem_ready,
    input  logic       alu_zero,
    input  logic [5:0] instr_func,
    output ctrl_t      ctrl
);

    always_comb begin
        ctrl = ctrl_default();
        unique case (state)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                // IR load and PC+4 update happen in the cycle memory completes
                ctrl.ir_write  = mem_ready;
                ctrl.pc_en     = mem_ready;
            end
            S_DECODE: begin
                ctrl.alu_src_b = SRCB_IMM_SH2;
            end
            S_MEMADR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
            end
            S_MEMRD: begin
                ctrl.mem_read = 1'b1;
                ctrl.iord     = 1'b1;
            end
            S_MEMWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.retire     = 1'b1;
            end
            S_MEMWR: begin
                ctrl.mem_write = 1'b1;
                ctrl.iord      = 1'b1;
                ctrl.retire    = mem_ready;
            end
            S_EXEC: begin
                ctrl.alu_src_a  = 1'b1;
                ctrl.alu_opcode = ALU_RTYPE_OP;
                ctrl.alu_func   = instr_func;
            end
            S_ALUWB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
                ctrl.retire    = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a  = 1'b1;
                ctrl.alu_opcode = ALU_SUB_OP;
                ctrl.pc_source  = PCSRC_ALUOUT;
                // Not taken leaves the PC+4 written during FETCH
                ctrl.pc_en      = alu_zero;
                ctrl.retire     = 1'b1;
            end
            S_JUMP: begin
                ctrl.pc_source = PCSRC_JUMP;
                ctrl.pc_en     = 1'b1;
                ctrl.retire    = 1'b1;
            end
            S_ADDI_EX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
            end
            S_ADDI_WB: begin
                ctrl.reg_write = 1'b1;
                ctrl.retire    = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control unit: state register, next-state logic, retired
// instruction counter. Inputs: clk, rst, IR opcode/func, alu_zero, mem_ready.
// Outputs: memory strobes, datapath enables/selects, ALU command, status.
module mips_multicycle_ctrl
    import mips_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  instr_opcode,
    input  logic [5:0]  instr_func,
    input  logic        alu_zero,
    input  logic        mem_ready,
    output logic        mem_read,
    output logic        mem_write,
    output logic        iord,
    output logic        ir_write,
    output logic        pc_en,
    output logic        reg_write,
    output logic        reg_dst,
    output logic        mem_to_reg,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  pc_source,
    output logic [5:0]  alu_opcode,
    output logic [5:0]  alu_func,
    output logic        illegal,
    output logic        retire,
    output logic [31:0] instr_count,
    output logic [3:0]  state_o
);

    state_e      state_q, state_d;
    logic [31:0] instr_count_q, instr_count_d;
    logic        illegal_raw;
    ctrl_t       ctrl_raw, ctrl_out;

    mips_ctrl_outdec u_outdec (
        .state      (state_q),
        .mem_ready  (mem_ready),
        .alu_zero   (alu_zero),
        .instr_func (instr_func),
        .ctrl       (ctrl_raw)
    );

    always_comb begin
        state_d     = state_q;
        illegal_raw = 1'b0;
        unique case (state_q)
            S_FETCH:  if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                unique case (instr_opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    OP_ADDI:      state_d = S_ADDI_EX;
                    default: begin
                        illegal_raw = 1'b1;
                        state_d     = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: state_d = (instr_opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
            S_MEMWR:  if (mem_ready) state_d = S_FETCH;
            S_EXEC:   state_d = S_ALUWB;
            S_ADDI_EX: state_d = S_ADDI_WB;
            default:  state_d = S_FETCH;
        endcase
    end

    // Reset silences every output in the same cycle it is asserted
    always_comb begin
        ctrl_out      = rst ? ctrl_default() : ctrl_raw;
        instr_count_d = instr_count_q + {31'd0, ctrl_out.retire};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_FETCH;
            instr_count_q <= 32'd0;
        end else begin
            state_q       <= state_d;
            instr_count_q <= instr_count_d;
        end
    end

    assign mem_read    = ctrl_out.mem_read;
    assign mem_write   = ctrl_out.mem_write;
    assign iord        = ctrl_out.iord;
    assign ir_write    = ctrl_out.ir_write;
    assign pc_en       = ctrl_out.pc_en;
    assign reg_write   = ctrl_out.reg_write;
    assign reg_dst     = ctrl_out.reg_dst;
    assign mem_to_reg  = ctrl_out.mem_to_reg;
    assign alu_src_a   = ctrl_out.alu_src_a;
    assign alu_src_b   = ctrl_out.alu_src_b;
    assign pc_source   = ctrl_out.pc_source;
    assign alu_opcode  = ctrl_out.alu_opcode;
    assign alu_func    = ctrl_out.alu_func;
    assign retire      = ctrl_out.retire;
    assign illegal     = illegal_raw & ~rst;
    assign instr_count = instr_count_q;
    assign state_o     = rst ? 4'd0 : state_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Scoreboard bench for mips_multicycle_ctrl: per-cycle expected outputs and
// per-instruction latency are queued by the driver and checked by a monitor.
module tb_mips_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [5:0]  instr_opcode = '0;
    logic [5:0]  instr_func = '0;
    logic        alu_zero = 1'b0;
    logic        mem_ready = 1'b0;
    logic        mem_read, mem_write, iord, ir_write, pc_en;
    logic        reg_write, reg_dst, mem_to_reg, alu_src_a;
    logic [1:0]  alu_src_b, pc_source;
    logic [5:0]  alu_opcode, alu_func;
    logic        illegal, retire;
    logic [31:0] instr_count;
    logic [3:0]  state_o;

    always #5 clk = ~clk;

    mips_multicycle_ctrl dut (
        .clk(clk), .rst(rst),
        .instr_opcode(instr_opcode), .instr_func(instr_func),
        .alu_zero(alu_zero), .mem_ready(mem_ready),
        .mem_read(mem_read), .mem_write(mem_write), .iord(iord),
        .ir_write(ir_write), .pc_en(pc_en), .reg_write(reg_write),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .pc_source(pc_source), .alu_opcode(alu_opcode),
        .alu_func(alu_func), .illegal(illegal), .retire(retire),
        .instr_count(instr_count), .state_o(state_o)
    );

    typedef struct packed {
        logic [3:0]  st;
        logic        mr, mw, iord, irw, pce, rw, rd, m2r, asa;
        logic [1:0]  asb, pcs;
        logic [5:0]  aop, afn;
        logic        ill, ret;
        logic [31:0] cnt;
        logic        full;
    } obs_t;

    typedef struct packed {
        logic        ill;
        int unsigned lat;
    } ins_t;

    obs_t        cycq[$];
    ins_t        instq[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] mcnt = '0;
    logic [5:0]  cur_op = '0;
    logic [5:0]  cur_fn = '0;

    function automatic logic rb();
        return 1'($urandom() & 32'd1);
    endfunction

    function automatic obs_t base(input logic [3:0] st);
        obs_t e;
        e      = '0;
        e.st   = st;
        e.aop  = 6'h23;
        e.cnt  = mcnt;
        e.full = 1'b1;
        return e;
    endfunction

    // Fields the design guarantees while reset is held
    function automatic logic [42:0] rmask(input obs_t o);
        return {o.st, o.mr, o.mw, o.irw, o.pce, o.rw, o.ill, o.ret, o.cnt};
    endfunction

    task automatic cyc(input obs_t e, input logic r, input logic mr,
                       input logic z);
        @(negedge clk);
        rst          = r;
        mem_ready    = mr;
        alu_zero     = z;
        instr_opcode = cur_op;
        instr_func   = cur_fn;
        cycq.push_back(e);
    endtask

    // Latency table from the instruction set, independent of the state walk
    function automatic int base_lat(input logic [5:0] op);
        case (op)
            6'h23:               return 5;
            6'h2B, 6'h00, 6'h08: return 4;
            6'h04, 6'h02:        return 3;
            default:             return 2;
        endcase
    endfunction

    task automatic run(input logic [5:0] op, input logic [5:0] fn,
                       input logic z, input int wf, input int wm,
                       input bit abort);
        obs_t e;
        ins_t x;
        bit   mem;
        int   bl;
        bl     = base_lat(op);
        mem    = (op == 6'h23) || (op == 6'h2B);
        cur_op = op;
        cur_fn = fn;
        if (!abort) begin
            x.ill = (bl == 2);
            x.lat = bl + wf + (mem ? wm : 0);
            instq.push_back(x);
        end
        repeat (wf) begin
            e = base(0); e.mr = 1; e.asb = 2'b01;
            cyc(e, 0, 0, rb());
        end
        e = base(0); e.mr = 1; e.asb = 2'b01; e.irw = 1; e.pce = 1;
        cyc(e, 0, 1, rb());
        e = base(1); e.asb = 2'b11; e.ill = (bl == 2);
        cyc(e, 0, rb(), rb());
        if (bl == 2) return;
        if (mem) begin
            e = base(2); e.asa = 1; e.asb = 2'b10;
            cyc(e, 0, rb(), rb());
            if (op == 6'h23) begin
                repeat (wm) begin
                    e = base(3); e.mr = 1; e.iord = 1;
                    cyc(e, 0, 0, rb());
                end
                if (abort) begin
                    e = '0; e.cnt = mcnt;
                    cyc(e, 1, rb(), rb());
                    mcnt = '0;
                    return;
                end
                e = base(3); e.mr = 1; e.iord = 1;
                cyc(e, 0, 1, rb());
                e = base(4); e.rw = 1; e.m2r = 1; e.ret = 1;
                cyc(e, 0, rb(), rb());
                mcnt++;
            end else begin
                repeat (wm) begin
                    e = base(5); e.mw = 1; e.iord = 1;
                    cyc(e, 0, 0, rb());
                end
                e = base(5); e.mw = 1; e.iord = 1; e.ret = 1;
                cyc(e, 0, 1, rb());
                mcnt++;
            end
            return;
        end
        case (op)
            6'h00: begin
                e = base(6); e.asa = 1; e.aop = 6'h00; e.afn = fn;
                cyc(e, 0, rb(), rb());
                e = base(7); e.rw = 1; e.rd = 1; e.ret = 1;
                cyc(e, 0, rb(), rb());
            end
            6'h04: begin
                e = base(8); e.asa = 1; e.aop = 6'h04; e.pcs = 2'b01;
                e.pce = z; e.ret = 1;
                cyc(e, 0, rb(), z);
            end
            6'h02: begin
                e = base(9); e.pcs = 2'b10; e.pce = 1; e.ret = 1;
                cyc(e, 0, rb(), rb());
            end
            default: begin
                e = base(10); e.asa = 1; e.asb = 2'b10;
                cyc(e, 0, rb(), rb());
                e = base(11); e.rw = 1; e.ret = 1;
                cyc(e, 0, rb(), rb());
            end
        endcase
        mcnt++;
    endtask

    // Monitor: compares every queued cycle and every completion event
    initial begin
        obs_t a, e;
        ins_t x;
        int   lat;
        lat = 0;
        forever begin
            @(negedge clk);
            #2;
            if (cycq.size() != 0) begin
                e = cycq.pop_front();
                a = '{st: state_o, mr: mem_read, mw: mem_write,
                      iord: iord, irw: ir_write, pce: pc_en,
                      rw: reg_write, rd: reg_dst, m2r: mem_to_reg,
                      asa: alu_src_a, asb: alu_src_b, pcs: pc_source,
                      aop: alu_opcode, afn: alu_func, ill: illegal,
                      ret: retire, cnt: instr_count, full: e.full};
                n_cmp++;
                if (e.full ? (a !== e) : (rmask(a) !== rmask(e))) begin
                    n_bad++;
                    $display("FAIL cycle t=%0t got=%h want=%h",
                             $time, a, e);
                end
            end
            if (rst) begin
                lat = 0;
            end else begin
                lat++;
                if (retire === 1'b1 || illegal === 1'b1) begin
                    n_cmp++;
                    if (instq.size() == 0) begin
                        n_bad++;
                        $display("FAIL unexpected_end t=%0t got ret=%b ill=%b want none",
                                 $time, retire, illegal);
                    end else begin
                        x = instq.pop_front();
                        if (x.lat != lat || x.ill !== illegal) begin
                            n_bad++;
                            $display("FAIL latency t=%0t got=%0d/ill%b want=%0d/ill%b",
                                     $time, lat, illegal, x.lat, x.ill);
                        end
                    end
                    lat = 0;
                end
            end
        end
    end

    // Driver
    initial begin
        obs_t        e;
        logic [5:0]  ops [6];
        logic [5:0]  op;
        ops = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h08};
        repeat (2) @(negedge clk);
        e = '0;
        cyc(e, 1, 0, 0);
        run(6'h23, 6'h00, 0, 0, 0, 0);
        run(6'h00, 6'h20, 0, 0, 0, 0);
        run(6'h04, 6'h11, 1, 0, 0, 0);
        run(6'h04, 6'h11, 0, 0, 0, 0);
        run(6'h2B, 6'h00, 0, 3, 2, 0);
        run(6'h08, 6'h05, 0, 1, 0, 0);
        run(6'h3F, 6'h00, 0, 0, 0, 0);
        run(6'h23, 6'h00, 0, 1, 1, 1);
        run(6'h3F, 6'h00, 0, 0, 0, 0);
        #3;
        force dut.instr_count_q = 32'hFFFF_FFFF;
        #1;
        release dut.instr_count_q;
        mcnt = 32'hFFFF_FFFF;
        run(6'h02, 6'h00, 0, 0, 0, 0);
        run(6'h08, 6'h00, 0, 0, 0, 0);
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(9, 0) == 0) op = 6'($urandom());
            else op = ops[$urandom_range(5, 0)];
            run(op, 6'($urandom()), rb(), $urandom_range(3, 0),
                $urandom_range(3, 0), 0);
        end
        @(negedge clk);
        mem_ready = 1'b0;
        repeat (4) @(negedge clk);
        n_cmp++;
        if (instq.size() != 0 || cycq.size() != 0) begin
            n_bad++;
            $display("FAIL drain got=%0d/%0d pending want=0/0",
                     instq.size(), cycq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mips_multicycle_ctrl.md
# mips_multicycle_ctrl

Multicycle MIPS control unit: the initiator side of the ALU interface. Sequences each instruction through fetch, decode, execute, memory and writeback states. Drives the ALU's `opcode`/`func_field` and the datapath muxes, and consumes the ALU `zero` flag for branches. It sits between the instruction register / memory port and the `Alu_Top` + register-file datapath.

## Interface
No parameters.
- `clk` in 1: single clock; every register updates on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `instr_opcode` in 6: IR[31:26].
- `instr_func` in 6: IR[5:0].
- `alu_zero` in 1: ALU `zero` output.
- `mem_ready` in 1: memory has completed the current read or write this cycle.
- `mem_read`, `mem_write`, `iord` out 1: memory strobes; `iord`=1 selects the ALUOut address.
- `ir_write`, `pc_en`, `reg_write`, `reg_dst`, `mem_to_reg` out 1: datapath enables and selects.
- `alu_src_a` out 1: 0 = PC, 1 = regA.
- `alu_src_b` out 2: 00 = regB, 01 = 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2.
- `pc_source` out 2: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `alu_opcode`, `alu_func` out 6 each: drive the ALU `opcode` / `func_field` inputs.
- `illegal` out 1: one-cycle pulse for an unsupported opcode.
- `retire` out 1: one-cycle pulse in the final state of each instruction.
- `instr_count` out 32: count of retired instructions.
- `state_o` out 4: current state, for debug.

## Operation
- Supported opcodes: R-type 0x00, LW 0x23, SW 0x2B, BEQ 0x04, J 0x02, ADDI 0x08.
- ALU command encoding (the ALU control decode is fixed):
  - `alu_opcode`=0x23 with `alu_func`=0 means add.
  - `alu_opcode`=0x04 means subtract.
  - `alu_opcode`=0x00 means use `alu_func`.
- Default outputs in every state: all strobes 0, selects 0, `alu_opcode`=0x23, `alu_func`=0. Each state below lists only what differs from the default.
- States (encoding 0–11) and their actions:
  - FETCH(0): `mem_read`=1, `alu_src_b`=01. When `mem_ready`=1: `ir_write`=1, `pc_en`=1, next DECODE. Otherwise stay in FETCH.
  - DECODE(1): `alu_src_b`=11 (precompute branch target). Next state by opcode: MEMADR for LW/SW, EXEC for R-type, BRANCH, JUMP, ADDI_EX. Any other opcode: `illegal`=1, next FETCH.
  - MEMADR(2): `alu_src_a`=1, `alu_src_b`=10. Next MEMRD for LW, MEMWR for SW.
  - MEMRD(3): `mem_read`=1, `iord`=1. Wait for `mem_ready`, then MEMWB.
  - MEMWB(4): `reg_write`=1, `mem_to_reg`=1, `retire`=1. Next FETCH.
  - MEMWR(5): `mem_write`=1, `iord`=1. Wait for `mem_ready`; in that cycle `retire`=1, next FETCH.
  - EXEC(6): `alu_src_a`=1, `alu_opcode`=0x00, `alu_func`=`instr_func`. Next ALUWB.
  - ALUWB(7): `reg_write`=1, `reg_dst`=1, `retire`=1. Next FETCH.
  - BRANCH(8): `alu_src_a`=1, `alu_opcode`=0x04, `pc_source`=01, `pc_en`=`alu_zero`, `retire`=1. Next FETCH.
  - JUMP(9): `pc_source`=10, `pc_en`=1, `retire`=1. Next FETCH.
  - ADDI_EX(10): `alu_src_a`=1, `alu_src_b`=10. Next ADDI_WB.
  - ADDI_WB(11): `reg_write`=1, `retire`=1. Next FETCH.
- `instr_count` increments by 1 on every cycle with `retire`=1 and wraps from 0xFFFFFFFF to 0. `illegal` does not count.
- `instr_opcode` and `instr_func` are sampled only in DECODE, EXEC, MEMADR, MEMRD and MEMWR. The IR holds them stable from FETCH completion onward.

## Timing
- State is registered; outputs are decoded from the registered state.
- `pc_en` (via `mem_ready` and `alu_zero`) and the FETCH/MEMWR completion strobes are same-cycle Mealy terms.
- Latency with `mem_ready` tied high:
  - LW: 5 cycles.
  - SW, R-type, ADDI: 4 cycles.
  - BEQ, J: 3 cycles.
  - Each cycle `mem_ready` is low in FETCH, MEMRD or MEMWR adds one cycle.
- Reset, with `rst` sampled high at any edge, including mid-instruction:
  - next state is FETCH and `instr_count` is 0;
  - while `rst` is high, all strobe outputs are forced to 0 and `state_o` reads 0;
  - the first cycle after `rst` falls is a FETCH.
- A branch with `alu_zero` low does not write the PC; the PC keeps PC+4 from FETCH.
- `mem_ready` is ignored in every state except FETCH, MEMRD and MEMWR.

## Structure
- Package `mips_ctrl_pkg` holds:
  - state encodings;
  - opcode constants;
  - `alu_src_b` and `pc_source` encodings;
  - ALU command constants (ALU_ADD_OP=0x23, ALU_SUB_OP=0x04, ALU_RTYPE_OP=0x00).
- One sub-module, `mips_ctrl_outdec`: combinational decode of (state, `mem_ready`, `alu_zero`, `instr_func`) into all control outputs.
- The top level holds the state register, the next-state logic and `instr_count`.

## Test plan
- **LW, memory ready:** reset, then LW (0x23), `mem_ready`=1.
  - Required: states 0→1→2→3→4→0.
  - Required: `reg_write`=1 with `mem_to_reg`=1 in cycle 5, and `instr_count`=1.
- **R-type add:** R-type with `instr_func`=0x20.
  - Required in EXEC: `alu_opcode`=0x00, `alu_func`=0x20, `alu_src_a`=1.
  - Required in the next cycle: `reg_write`=1, `reg_dst`=1.
- **BEQ taken and not taken:** BEQ with `alu_zero`=1 → `pc_en`=1 and `pc_source`=01 in BRANCH. BEQ with `alu_zero`=0 → `pc_en`=0 in BRANCH.
- **Memory wait states:** hold `mem_ready`=0 for 3 cycles in FETCH, then SW with `mem_ready`=0 for 2 cycles in MEMWR.
  - Required: state holds in each wait; no `ir_write` before `mem_ready` rises.
  - Required: SW totals 4+3+2 = 9 cycles, with `retire` only on the last.
- **Illegal opcode:** opcode 0x3F → `illegal` pulses once in DECODE, next state FETCH, `instr_count` unchanged.
- **Reset mid-instruction:** assert `rst` in MEMRD → next cycle `state_o`=0, all strobes 0, `instr_count`=0. Force `instr_count` to 0xFFFFFFFF and retire a J → it wraps to 0.
